// File: rtl/riscv_lsu.sv
// riscv_lsu -- load-store unit between the core datapath and a ready-handshaked
// data memory. Stalls the core while an access is outstanding, aligns and
// sign/zero-extends load data, and reports misaligned or timed-out accesses.
//
// Ports
//   clk_i, rst_i       clock, asynchronous active-high reset
//   core_req_i         access request from the decoder
//   core_we_i          1 = store, 0 = load
//   core_size_i        0=B 1=H 2=W 4=BU 5=HU (other codes behave as W)
//   core_addr_i        byte address
//   core_wd_i          store data
//   core_rd_o          aligned, extended load data (registered)
//   core_stall_o       hold PC and pipeline while 1
//   core_misalign_o    1-cycle pulse, misaligned request rejected
//   core_fault_o       1-cycle pulse, access timed out
//   mem_req_o/we_o     memory request / write enable
//   mem_be_o           byte enables
//   mem_addr_o         word-aligned address
//   mem_wd_o           replicated store data
//   mem_rd_i           memory read word
//   mem_ready_i        access complete this cycle
module riscv_lsu #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        core_misalign_o,
  output logic        core_fault_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  // The counter never exceeds TIMEOUT-1: reaching it ends the access.
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [31:0]    rd_q, rd_d;

  logic        is_byte, is_half, is_unsigned, misalign, active, timeout_hit;
  logic [3:0]  be_raw;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign is_byte     = (core_size_i == 3'd0) || (core_size_i == 3'd4);
  assign is_half     = (core_size_i == 3'd1) || (core_size_i == 3'd5);
  assign is_unsigned = core_size_i[2];
  assign misalign    = is_half ? core_addr_i[0] :
                       is_byte ? 1'b0 : (core_addr_i[1:0] != 2'b00);

  // NOTE: the request/stall path is gated by rst_i directly so that an
  // asserted reset drops them in the same cycle, not at the next edge.
  assign active      = ~rst_i & core_req_i & ~misalign & (state_q != DONE);
  assign timeout_hit = (state_q == BUSY) & active & ~mem_ready_i & (cnt_q == CNT_LAST);

  assign be_raw = is_byte ? (4'b0001 << core_addr_i[1:0]) :
                  is_half ? (4'b0011 << {core_addr_i[1], 1'b0}) : 4'b1111;

  always_comb begin
    ld_byte = mem_rd_i[7:0];
    case (core_addr_i[1:0])
      2'd1:    ld_byte = mem_rd_i[15:8];
      2'd2:    ld_byte = mem_rd_i[23:16];
      2'd3:    ld_byte = mem_rd_i[31:24];
      default: ld_byte = mem_rd_i[7:0];
    endcase
  end

  assign ld_half = core_addr_i[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
  assign ld_data = is_byte ? {{24{~is_unsigned & ld_byte[7]}}, ld_byte} :
                   is_half ? {{16{~is_unsigned & ld_half[15]}}, ld_half} : mem_rd_i;

  // Next-state and output logic.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_d         = state_q;
    cnt_d           = cnt_q;
    rd_d            = rd_q;
    mem_req_o       = active;
    mem_we_o        = active & core_we_i;
    mem_be_o        = active ? be_raw : 4'b0000;
    mem_addr_o      = {core_addr_i[31:2], 2'b00};
    mem_wd_o        = is_byte ? {4{core_wd_i[7:0]}} :
                      is_half ? {2{core_wd_i[15:0]}} : core_wd_i;
    core_stall_o    = active & ~timeout_hit;
    core_misalign_o = ~rst_i & core_req_i & misalign & (state_q == IDLE);
    core_fault_o    = timeout_hit;

    case (state_q)
      IDLE: begin
        if (active) begin
          cnt_d   = '0;
          state_d = mem_ready_i ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (!active)              state_d = IDLE;   // request withdrawn (flush)
        else if (mem_ready_i)     state_d = DONE;
        else if (timeout_hit)     state_d = DONE;
        else                      cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = IDLE;                       // DONE
    endcase

    // Load data is captured only on the completing cycle of a live load.
    if (active && mem_ready_i && !core_we_i) rd_d = ld_data;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values computed before the edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
    end
  end

  assign core_rd_o = rd_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu. Expected load results go into a scoreboard
// queue when the load is issued and are popped when the access reaches DONE.
module tb_riscv_lsu;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        core_req_i, core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i, core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_o, core_misalign_o, core_fault_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wd_o, mem_rd_i;
  logic        mem_ready_i;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rd;

  riscv_lsu #(.TIMEOUT(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .core_req_i(core_req_i), .core_we_i(core_we_i), .core_size_i(core_size_i),
    .core_addr_i(core_addr_i), .core_wd_i(core_wd_i), .core_rd_o(core_rd_o),
    .core_stall_o(core_stall_o), .core_misalign_o(core_misalign_o),
    .core_fault_o(core_fault_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o),
    .mem_rd_i(mem_rd_i), .mem_ready_i(mem_ready_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic we, input logic [2:0] size,
                       input logic [31:0] addr, input logic [31:0] wd);
    core_req_i  = 1'b1;
    core_we_i   = we;
    core_size_i = size;
    core_addr_i = addr;
    core_wd_i   = wd;
  endtask

  task automatic check_load_done(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check(tag, core_rd_o, e);
      last_rd = e;
    end
  endtask

  // Single-cycle access: ready in the issue cycle, DONE next, back to IDLE.
  task automatic quick_access(input string tag, input logic we, input logic [2:0] size,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] rdata, input logic [3:0] exp_be,
                              input logic [31:0] exp_val);
    drive(we, size, addr, wd);
    mem_rd_i    = rdata;
    mem_ready_i = 1'b1;
    #1;
    check({tag, "_be"},    {28'd0, mem_be_o}, {28'd0, exp_be});
    check({tag, "_stall"}, {31'd0, core_stall_o}, 32'd1);
    check({tag, "_we"},    {31'd0, mem_we_o}, {31'd0, we});
    check({tag, "_addr"},  mem_addr_o, {addr[31:2], 2'b00});
    if (we) check({tag, "_wd"}, mem_wd_o, exp_val);
    else    exp_q.push_back(exp_val);
    step();
    mem_ready_i = 1'b0;
    core_req_i  = 1'b0;
    #1;
    check({tag, "_done_stall"}, {31'd0, core_stall_o}, 32'd0);
    if (we) check({tag, "_rd_kept"}, core_rd_o, last_rd);
    else    check_load_done({tag, "_rd"});
    step();
  endtask

  initial begin
    rst_i = 1'b1;
    drive(1'b0, 3'd2, 32'h100, 32'h0);
    mem_rd_i = 32'h0; mem_ready_i = 1'b0;
    last_rd = 32'h0;
    #3;
    // Reset: everything low even with a request pending.
    check("rst_stall", {31'd0, core_stall_o}, 32'd0);
    check("rst_req",   {31'd0, mem_req_o}, 32'd0);
    check("rst_be",    {28'd0, mem_be_o}, 32'd0);
    check("rst_rd",    core_rd_o, 32'd0);
    check("rst_flags", {30'd0, core_misalign_o, core_fault_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0; core_req_i = 1'b0;
    step();

    // LW 0x100, ready on third cycle: three stall cycles.
    drive(1'b0, 3'd2, 32'h100, 32'h0);
    #1;
    check("lw_stall0", {31'd0, core_stall_o}, 32'd1);
    check("lw_req",    {31'd0, mem_req_o}, 32'd1);
    check("lw_be",     {28'd0, mem_be_o}, 32'hF);
    check("lw_we",     {31'd0, mem_we_o}, 32'd0);
    exp_q.push_back(32'hDEADBEEF);
    step();
    check("lw_stall1", {31'd0, core_stall_o}, 32'd1);
    step();
    mem_rd_i = 32'hDEADBEEF; mem_ready_i = 1'b1;
    #1;
    check("lw_stall2", {31'd0, core_stall_o}, 32'd1);
    step();
    mem_ready_i = 1'b0;
    #1;
    check("lw_done_stall", {31'd0, core_stall_o}, 32'd0);
    check("lw_done_req",   {31'd0, mem_req_o}, 32'd0);
    check_load_done("lw_rd");
    core_req_i = 1'b0;
    step();

    quick_access("lb",  1'b0, 3'd0, 32'h103, 32'h0, 32'h80123456, 4'b1000, 32'hFFFFFF80);
    quick_access("lbu", 1'b0, 3'd4, 32'h103, 32'h0, 32'h80123456, 4'b1000, 32'h00000080);
    quick_access("lh",  1'b0, 3'd1, 32'h106, 32'h0, 32'h80012345, 4'b1100, 32'hFFFF8001);
    quick_access("lhu", 1'b0, 3'd5, 32'h106, 32'h0, 32'h80012345, 4'b1100, 32'h00008001);
    quick_access("sh",  1'b1, 3'd1, 32'h102, 32'h1234ABCD, 32'h0, 4'b1100, 32'hABCDABCD);
    quick_access("sb",  1'b1, 3'd0, 32'h101, 32'h0000775A, 32'h0, 4'b0010, 32'h5A5A5A5A);

    // Misaligned LW: rejected with a one-cycle pulse.
    drive(1'b0, 3'd2, 32'h101, 32'h0);
    #1;
    check("mis_pulse", {31'd0, core_misalign_o}, 32'd1);
    check("mis_req",   {31'd0, mem_req_o}, 32'd0);
    check("mis_stall", {31'd0, core_stall_o}, 32'd0);
    check("mis_be",    {28'd0, mem_be_o}, 32'd0);
    step();
    core_req_i = 1'b0;
    #1;
    check("mis_clear", {31'd0, core_misalign_o}, 32'd0);

    // Timeout: fault on the 16th BUSY cycle, stall released then.
    drive(1'b0, 3'd2, 32'h200, 32'h0);
    #1;
    check("to_stall0", {31'd0, core_stall_o}, 32'd1);
    for (int i = 1; i <= 16; i++) begin
      step();
      check($sformatf("to_fault_c%0d", i), {31'd0, core_fault_o}, {31'd0, i == 16});
      check($sformatf("to_stall_c%0d", i), {31'd0, core_stall_o}, {31'd0, i != 16});
    end
    step();
    core_req_i = 1'b0;
    #1;
    check("to_done_fault", {31'd0, core_fault_o}, 32'd0);
    check("to_rd_kept",    core_rd_o, last_rd);
    step();

    // Flush in BUSY; ready while idle must not touch the load register.
    drive(1'b0, 3'd2, 32'h300, 32'h0);
    step();
    core_req_i = 1'b0; mem_ready_i = 1'b1; mem_rd_i = 32'h55555555;
    #1;
    check("fl_stall", {31'd0, core_stall_o}, 32'd0);
    step();
    check("fl_rd_kept", core_rd_o, last_rd);
    step();
    check("idle_ready_ignored", core_rd_o, last_rd);
    mem_ready_i = 1'b0;
    quick_access("after_flush", 1'b0, 3'd2, 32'h300, 32'h0, 32'h11112222, 4'b1111, 32'h11112222);

    // Reset mid-access, then a normal LW.
    drive(1'b0, 3'd2, 32'h400, 32'h0);
    step();
    #2;
    rst_i = 1'b1;
    #1;
    check("rb_stall", {31'd0, core_stall_o}, 32'd0);
    check("rb_req",   {31'd0, mem_req_o}, 32'd0);
    check("rb_rd",    core_rd_o, 32'd0);
    last_rd = 32'h0;
    step();
    rst_i = 1'b0;
    drive(1'b0, 3'd2, 32'h404, 32'h0);
    #1;
    check("ar_stall0", {31'd0, core_stall_o}, 32'd1);
    exp_q.push_back(32'hCAFEF00D);
    step();
    mem_rd_i = 32'hCAFEF00D; mem_ready_i = 1'b1;
    #1;
    check("ar_stall1", {31'd0, core_stall_o}, 32'd1);
    step();
    mem_ready_i = 1'b0; core_req_i = 1'b0;
    #1;
    check("ar_done_stall", {31'd0, core_stall_o}, 32'd0);
    check_load_done("ar_rd");
    check("sb_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
